// File: rtl/mspi.sv
// Host-side serial bridge: Wishbone classic slave -> clk/mosi/miso frame to a remote WB slave.
// Optional wait-phase abort is compiled in with `define MSPI_TIMEOUT_EN.
module mspi #(
  parameter int unsigned HALF_PERIOD   = 8,
  parameter int unsigned TIMEOUT_SLOTS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [23:0] wb_adr,
  input  logic [15:0] wb_i_dat,
  input  logic [1:0]  wb_sel,
  output logic [15:0] wb_o_dat,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [8:0] SlotLast  = 9'(2 * HALF_PERIOD - 1);
  localparam logic [8:0] HighStart = 9'(HALF_PERIOD);
  localparam logic [5:0] CmdLastRd = 6'd25;
  localparam logic [5:0] CmdLastWr = 6'd41;
  localparam logic [5:0] RdLast    = 6'd15;

  typedef enum logic [2:0] {StIdle, StCmd, StWait, StRdata, StResp, StDone} state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic [41:0] shreg_q, shreg_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        clk_q, clk_d;
  logic        mosi_q, mosi_d;
  logic        miso_s1_q, miso_s2_q;
  logic        slot_end;
  logic        in_slot;

`ifdef MSPI_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_SLOTS + 1);
  localparam logic [ToW-1:0] WaitLast = ToW'(TIMEOUT_SLOTS - 1);
  logic [ToW-1:0] wait_cnt_q, wait_cnt_d;
`else
  localparam int unsigned unused_timeout_slots = TIMEOUT_SLOTS;
`endif

  logic unused_sel;
  assign unused_sel = ^wb_sel;

  assign slot_end = (cnt_q == SlotLast);
  assign in_slot  = (state_q == StCmd) || (state_q == StWait) ||
                    (state_q == StRdata) || (state_q == StResp);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mosi_d  = mosi_q;
    clk_d   = 1'b0;
`ifdef MSPI_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif

    // Phase counter runs only inside a slot; spi_clk is high for the second half.
    if (in_slot) begin
      cnt_d = slot_end ? 9'd0 : cnt_q + 9'd1;
      clk_d = !slot_end && ((cnt_q + 9'd1) >= HighStart);
    end

    unique case (state_q)
      StIdle: begin
        mosi_d = 1'b1;
        if (wb_cyc && wb_stb) begin
          state_d = StCmd;
          cnt_d   = 9'd0;
          bit_d   = 6'd0;
          shreg_d = {wb_i_dat, wb_we, wb_adr, 1'b0};
          we_d    = wb_we;
          err_d   = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      StCmd: begin
        if (slot_end) begin
          shreg_d = {1'b0, shreg_q[41:1]};
          if (bit_q == (we_q ? CmdLastWr : CmdLastRd)) begin
            state_d = StWait;
            bit_d   = 6'd0;
            mosi_d  = 1'b1;
`ifdef MSPI_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end else begin
            bit_d  = bit_q + 6'd1;
            mosi_d = shreg_q[1];
          end
        end
      end
      StWait: begin
        if (slot_end) begin
          if (!miso_s2_q) begin
            state_d = we_q ? StResp : StRdata;
            bit_d   = 6'd0;
          end
`ifdef MSPI_TIMEOUT_EN
          else if (wait_cnt_q == WaitLast) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + ToW'(1);
          end
`endif
        end
      end
      StRdata: begin
        if (slot_end) begin
          rdata_d = {miso_s2_q, rdata_q[15:1]};
          if (bit_q == RdLast) begin
            state_d = StResp;
            bit_d   = 6'd0;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      StResp: begin
        if (slot_end) begin
          err_d   = miso_s2_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        mosi_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      clk_q     <= 1'b0;
      mosi_q    <= 1'b1;
      miso_s1_q <= 1'b1;
      miso_s2_q <= 1'b1;
`ifdef MSPI_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      clk_q     <= clk_d;
      mosi_q    <= mosi_d;
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
`ifdef MSPI_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Completion is suppressed when the master abandoned the cycle mid-frame.
  assign wb_ack   = (state_q == StDone) && wb_cyc && !err_q;
  assign wb_err   = (state_q == StDone) && wb_cyc && err_q;
  assign wb_o_dat = (wb_ack && !we_q) ? rdata_q : 16'h0000;
  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_mspi.sv
// Self-checking bench for mspi: behavioural remote serial slave plus per-transaction expectations.
module tb_mspi;
  localparam int unsigned HP = 6;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [23:0] adr;
  logic [15:0] idat;
  logic [15:0] odat;
  logic        ack, err;
  logic        sclk, mosi, miso;

  int n_checks = 0;
  int n_errors = 0;

  mspi #(.HALF_PERIOD(HP), .TIMEOUT_SLOTS(TO)) dut (
    .i_clk(clk), .i_rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
    .wb_i_dat(idat), .wb_sel(2'b11), .wb_o_dat(odat), .wb_ack(ack), .wb_err(err),
    .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Remote slave model: captures the command on spi_clk rises, replays its answer on falls.
  int          rm_wait = 2;
  logic [15:0] rm_rdata = '0;
  logic        rm_err_bit = 1'b0;
  logic        rm_cap[$];
  logic        rm_resp[$];
  logic        rm_collect, rm_prev;
  int          rm_rises, rm_frames, rm_last_slots;
  logic [23:0] rm_adr;
  logic        rm_we, rm_start;
  logic [15:0] rm_dat;

  initial begin
    rm_collect = 1'b1; rm_prev = 1'b0; miso = 1'b1;
    rm_rises = 0; rm_frames = 0; rm_last_slots = 0;
    rm_adr = '0; rm_we = 1'b0; rm_start = 1'b1; rm_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rm_cap.delete(); rm_resp.delete();
        rm_collect = 1'b1; rm_rises = 0; miso = 1'b1; rm_prev = sclk;
      end else begin
        if (sclk && !rm_prev) begin
          rm_rises++;
          if (rm_collect) begin
            rm_cap.push_back(mosi);
            if ((rm_cap.size() == 26 && !rm_cap[25]) || rm_cap.size() == 42) begin
              rm_start = rm_cap[0];
              for (int i = 0; i < 24; i++) rm_adr[i] = rm_cap[1+i];
              rm_we  = rm_cap[25];
              rm_dat = '0;
              if (rm_we) for (int i = 0; i < 16; i++) rm_dat[i] = rm_cap[26+i];
              for (int i = 0; i < rm_wait - 1; i++) rm_resp.push_back(1'b1);
              rm_resp.push_back(1'b0);
              if (!rm_we) for (int i = 0; i < 16; i++) rm_resp.push_back(rm_rdata[i]);
              rm_resp.push_back(rm_err_bit);
              rm_collect = 1'b0;
            end
          end
        end else if (!sclk && rm_prev && !rm_collect) begin
          if (rm_resp.size() > 0) begin
            miso = rm_resp.pop_front();
          end else begin
            miso = 1'b1;
            rm_collect = 1'b1;
            rm_last_slots = rm_rises;
            rm_rises = 0;
            rm_frames++;
            rm_cap.delete();
          end
        end
        rm_prev = sclk;
      end
    end
  end

  function automatic int frame_slots(input logic w_e, input int w);
    return (w_e ? 42 : 26) + w + (w_e ? 0 : 16) + 1;
  endfunction

  task automatic run_xfer(input string tag, input logic w_e, input logic [23:0] a,
                          input logic [15:0] d, input int w, input logic [15:0] rd,
                          input logic e);
    int slots, n, frames0;
    logic seen;
    slots = frame_slots(w_e, w);
    rm_wait = w; rm_rdata = rd; rm_err_bit = e; frames0 = rm_frames;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w_e; adr = a; idat = d;
    n = 0; seen = 1'b0;
    while (!seen && n < slots * 2 * HP + 50) begin
      @(posedge clk); #1;
      n++;
      if (ack || err) seen = 1'b1;
    end
    check({tag, " latency"}, n, slots * 2 * HP + 1);
    check({tag, " ack"}, ack, !e);
    check({tag, " err"}, err, e);
    if (!w_e && !e) check({tag, " rdata"}, odat, rd);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check({tag, " one-cycle pulse"}, {ack, err}, 2'b00);
    check({tag, " link idle"}, {sclk, mosi}, 2'b01);
    check({tag, " frame done"}, rm_frames, frames0 + 1);
    check({tag, " slots"}, rm_last_slots, slots);
    check({tag, " start bit"}, rm_start, 1'b0);
    check({tag, " adr"}, rm_adr, a);
    check({tag, " rw"}, rm_we, w_e);
    if (w_e) check({tag, " wdat"}, rm_dat, d);
  endtask

  initial begin
    int frames0, acks, n;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; idat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {sclk, mosi, ack, err}, 4'b0100);
    check("reset rdata", odat, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_xfer("wr", 1'b1, 24'h123456, 16'hBEEF, 3, 16'h0000, 1'b0);
    run_xfer("rd", 1'b0, 24'h00ABCD, 16'h0000, 3, 16'hA5C3, 1'b0);
    run_xfer("wr err", 1'b1, 24'h000F00, 16'h1234, 2, 16'h0000, 1'b1);

    for (int k = 0; k < 8; k++) begin
      run_xfer($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 24'($urandom),
               16'($urandom), int'($urandom_range(2, 5)), 16'($urandom),
               ($urandom_range(0, 4) == 0));
    end

    // Master abandons the cycle during CMD: frame completes, no completion pulse.
    rm_wait = 3; rm_rdata = '0; rm_err_bit = 1'b0; frames0 = rm_frames;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h55AA55; idat = 16'h0F0F;
    repeat (40) @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    acks = 0; n = 0;
    while (rm_frames == frames0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (ack || err) acks++;
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (ack || err) acks++;
    end
    check("drop frame done", rm_frames, frames0 + 1);
    check("drop slots", rm_last_slots, frame_slots(1'b1, 3));
    check("drop no ack", acks, 0);
    run_xfer("after drop", 1'b0, 24'h000123, 16'h0000, 4, 16'h3C3C, 1'b0);

    // Reset during RDATA.
    rm_wait = 3; rm_rdata = 16'hFFFF; rm_err_bit = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 24'hABCDEF;
    repeat ((26 + 3 + 5) * 2 * HP) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("rst mid outputs", {sclk, mosi, ack, err}, 4'b0100);
    check("rst mid rdata", odat, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst mid idle", {sclk, mosi}, 2'b01);
    run_xfer("after rst", 1'b1, 24'hFEDCBA, 16'h8001, 2, 16'h0000, 1'b0);

`ifdef MSPI_TIMEOUT_EN
    // Remote stays busy well past the abort limit.
    rm_wait = 100; rm_err_bit = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 24'h000001; idat = 16'h0001;
    n = 0; acks = 0;
    while (acks == 0 && n < (42 + TO) * 2 * HP + 50) begin
      @(posedge clk); #1;
      n++;
      if (ack || err) acks = 1;
    end
    check("timeout latency", n, (42 + TO) * 2 * HP + 1);
    check("timeout err", {ack, err}, 2'b01);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("timeout idle", {sclk, mosi, ack, err}, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mspi.md
# mspi

Host-side serial bridge: a Wishbone classic slave that turns each single-word bus access into one serial frame on a 4-wire-less (clk/mosi/miso) link and drives the remote serial-to-Wishbone slave at the far end. It sits on the local bus as a bridge window into a remote 24-bit address space. Exactly one transaction is outstanding at any time.

## Interface
- HALF_PERIOD, 8, i_clk cycles per spi_clk half-period; legal range 6..255
- TIMEOUT_SLOTS, 1024, max wait-phase bit slots before abort (used only with MSPI_TIMEOUT_EN)

- i_clk  in  1  system clock; all logic on posedge
- i_rst  in  1  reset, synchronous, active-high
- wb_cyc  in  1  bus cycle
- wb_stb  in  1  strobe
- wb_we  in  1  1 = write
- wb_adr  in  24  remote word address
- wb_i_dat  in  16  write data
- wb_sel  in  2  ignored; full 16-bit accesses only
- wb_o_dat  out  16  read data, valid with wb_ack
- wb_ack  out  1  one-cycle completion pulse
- wb_err  out  1  one-cycle error pulse (instead of wb_ack)
- spi_clk  out  1  serial clock, idle low
- spi_mosi  out  1  serial data out, idle high
- spi_miso  in  1  serial data in; passed through a 2-flop synchronizer before use

## Operation
- Bit slot = HALF_PERIOD cycles spi_clk low, then HALF_PERIOD cycles high. spi_mosi changes only on the first cycle of the low phase. Synchronized miso is sampled on the last cycle of the high phase.
- All multi-bit fields are sent and received LSB first.
- States: IDLE, CMD, WAIT, RDATA, RESP, DONE.
- IDLE: spi_clk=0, spi_mosi=1. On wb_cyc&wb_stb, latch adr/we/dat and go to CMD.
- CMD: shift start bit 0, then adr[0..23], then RW bit (1=write). For writes, follow with dat[0..15]. CMD is 26 slots for a read and 42 for a write; then go to WAIT.
- WAIT: mosi=1 and clocking continues. Each slot samples miso; 1 = remote busy. A sampled 0 ends the wait and goes to RDATA (read) or RESP (write).
- RDATA: 16 slots; sample i goes to rdata[i]; then RESP.
- RESP: 1 slot; the sampled bit is the remote error flag; then DONE.
- DONE, one cycle: if wb_cyc is still high, pulse wb_ack (flag 0) or wb_err (flag 1), and present wb_o_dat (read only). Return to IDLE; spi_clk is low and mosi high.
- wb_cyc/wb_stb deasserted mid-frame: the frame still completes on the link (no abort), ack/err is suppressed, and read data is discarded.
- A new request is not accepted until IDLE; wb_stb held across DONE starts a fresh transaction only in the following IDLE cycle.
- Reset values: spi_clk 0, spi_mosi 1, wb_ack 0, wb_err 0, wb_o_dat 0x0000, state IDLE, all counters 0.
- Reset mid-frame returns to IDLE immediately. The remote end is left desynchronized, so the remote end shall be reset alongside.

## Timing
- Frame length in slots:
  - write = 42 + W + 1
  - read = 26 + W + 16 + 1
  - W = number of wait slots including the terminating 0; W ≥ 2 is guaranteed by the remote (busy assert, then ack).
- Slot = 2·HALF_PERIOD cycles.
- Request-to-ack latency = 1 + slots·2·HALF_PERIOD + 1 cycles.
- wb_ack/wb_err are high for exactly one cycle and never together.
- HALF_PERIOD ≥ 6 guarantees the remote's miso update (its 3-stage clock sync plus output register) and this block's 2-flop sync settle before sampling, for equal clock rates.

## Configuration
- MSPI_TIMEOUT_EN defined:
  - WAIT counts slots; reaching TIMEOUT_SLOTS without a 0 goes to DONE with wb_err=1 (if wb_cyc high).
  - Returns to IDLE with link idle; rdata is not updated.
- Undefined: WAIT is unbounded and no counter is synthesized.

## Test plan
- Write adr 0x123456, dat 0xBEEF; remote model replies 1,1,0 then err 0 → mosi slots: 0, LSB-first 0x123456, 1, LSB-first 0xBEEF. Frame = 46 slots; one-cycle wb_ack, wb_err=0.
- Read adr 0x00ABCD; remote returns 0xA5C3, err 0 → wb_ack with wb_o_dat=0xA5C3, RW slot = 0, frame = 26+W+17 slots.
- Write with remote err bit 1 → single wb_err pulse, no wb_ack.
- MSPI_TIMEOUT_EN, TIMEOUT_SLOTS=8, miso stuck 1 → wb_err after 8 wait slots; spi_clk=0, mosi=1 afterwards.
- wb_cyc dropped during CMD → full frame still clocked; no ack/err; next request starts from IDLE cleanly.
- i_rst asserted mid-RDATA → next cycle spi_clk=0, mosi=1, wb_ack=0, wb_o_dat=0x0000, state IDLE.
